sincos_phase_sched: RTL and testbench
=====================================

Name: sincos_phase_sched

Overview:
Schedules the shared sincos CORDIC core across the three inverter legs (A, B, C).
- On each sample tick, advances a phase accumulator by a frequency word.
- Issues three phase requests to the core, one per leg: A, then A−2π/3, then A+2π/3.
- Collects the three in-order sin results and presents them as one aligned set with a valid strobe to the PWM modulator.

Parameters:
PHASE_W, 16, phase/sample width; signed Q3.13 radians
TIMEOUT_CYC, 32, max cycles from last issue to third result before abort

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  reset; asynchronous, active-low
en  in  1  when low, ticks are ignored and theta is held
tick  in  1  one-cycle sample strobe
freq_word  in  16  signed phase increment per tick; |freq_word| < PI_POS
clr_flags  in  1  clears sticky overrun and timeout_err
phase  out  16  phase to core; 0 when phase_tvalid=0
phase_tvalid  out  1  request valid to core
cos  in  16  core result (unused)
sin  in  16  core result
sincos_tvalid  in  1  core result valid; in order, no backpressure
sin_a, sin_b, sin_c  out  16 each  latched leg samples
out_valid  out  1  one-cycle strobe; set complete
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: tick arrived while busy
timeout_err  out  1  sticky: result set incomplete within TIMEOUT_CYC

Behaviour:
- Constants: PI_POS=0x6488 (25736), PI_NEG=−25736, TWO_PI=51472, TWO_PI_3=17157.
- Wrap arithmetic is 17-bit signed:
  - if x ≥ PI_POS, x−TWO_PI;
  - else if x < PI_NEG, x+TWO_PI;
  - result range is [−π, π); a single correction suffices.
- Reset: all outputs 0, theta=0, state IDLE.
- States: IDLE → ISS_A → ISS_B → ISS_C → WAIT → DONE → IDLE.
- IDLE:
  - when tick & en, theta <= wrap(theta+freq_word) and go to ISS_A;
  - tick with en=0 is ignored and not counted.
- ISS_A/B/C drive phase_tvalid=1 on three consecutive cycles:
  - ISS_A: phase=theta;
  - ISS_B: phase=wrap(theta−TWO_PI_3);
  - ISS_C: phase=wrap(theta+TWO_PI_3);
  - phase is registered: the tick in cycle N gives the ISS_A request in cycle N+1.
- Result collection:
  - a 2-bit result counter captures sin on each sincos_tvalid into sin_a, sin_b, sin_c in order;
  - results may arrive during the ISS states and are counted there;
  - after the third result, go to DONE;
  - out_valid=1 for the single DONE cycle, after which the state returns to IDLE;
  - sin_x hold their value until the next capture.
- Timeout: a counter starts at ISS_C. If the third result has not arrived after TIMEOUT_CYC cycles:
  - set timeout_err;
  - return to IDLE with no out_valid;
  - sin_x keep their previous set (partial captures are discarded via shadow registers).
- sincos_tvalid while IDLE, including stale results after reset or timeout, is ignored.
- A tick while busy (including DONE) sets overrun. That tick is dropped and theta is not advanced.
- clr_flags clears the sticky flags. If clr_flags coincides with a set event, the set wins.
- rst_n asserted mid-sequence immediately returns everything to reset values.

Optional Feature:
SINCOS_AMP_SCALE_EN
- Defined:
  - adds input amp[15:0], unsigned Q1.15 (0x8000 = 1.0);
  - each capture stores sat16((sin*amp)>>>15) via a registered multiply;
  - out_valid is delayed one cycle (DONE+1);
  - busy covers that extra cycle.
- Undefined: no amp port; raw sin is captured as specified above.

Decomposition:
- sincos_pkg: PI_POS, PI_NEG, TWO_PI, TWO_PI_3, PHASE_W, and the state enum.
- Sub-module phase_wrap: combinational 17-bit add plus single wrap correction; instantiated for theta update and the B/C offsets.

Test Plan:
- freq_word=256, theta=0, one tick → phase sequence 256, −16901, 17413 on cycles N+1..N+3; core model returning sin=phase → sin_a=256, sin_b=−16901, sin_c=17413 and out_valid once.
- theta preloaded to 25600 via 100 ticks at freq=256, then one more tick → ISS_A phase=−25616 (wrap); ISS_C = wrap(−25616+17157) = −8459.
- Core stub returns only two results → timeout_err=1 exactly TIMEOUT_CYC cycles after ISS_C; no out_valid; sin_a/b/c unchanged; a subsequent tick works normally.
- Tick during WAIT → overrun=1; theta unchanged; clr_flags → overrun=0.
- rst_n low during WAIT, then a late sincos_tvalid after release → all outputs 0, no capture, state IDLE.
- SINCOS_AMP_SCALE_EN, amp=0x4000, sin=0x4000 → sin_a=0x2000; out_valid at DONE+1.

Source files
------------

// File: rtl/sincos_phase_sched_pkg.sv
// Shared constants (Q3.13 radians), FSM state encoding and the saturation helper
// used by the leg scheduler; sat16 is only referenced when SINCOS_AMP_SCALE_EN is defined.
package sincos_phase_sched_pkg;

  localparam int PHASE_W = 16;

  localparam logic signed [PHASE_W:0]   PI_POS       = 17'sd25736;
  localparam logic signed [PHASE_W:0]   PI_NEG       = -17'sd25736;
  localparam logic signed [PHASE_W:0]   TWO_PI       = 17'sd51472;
  localparam logic signed [PHASE_W-1:0] TWO_PI_3     = 16'sd17157;
  localparam logic signed [PHASE_W-1:0] NEG_TWO_PI_3 = -16'sd17157;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISS_A,
    ST_ISS_B,
    ST_ISS_C,
    ST_WAIT,
    ST_DONE,
    ST_OUT
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767) begin
      return 16'sh7fff;
    end else if (x < -33'sd32768) begin
      return 16'sh8000;
    end
    return x[15:0];
  endfunction

endpackage

// File: rtl/sincos_phase_sched_if.sv
// Request/result channel between the leg scheduler (master) and the shared sincos core (slave).
interface sincos_phase_sched_if;
  import sincos_phase_sched_pkg::*;

  logic signed [PHASE_W-1:0] phase;
  logic                      phase_tvalid;
  logic signed [PHASE_W-1:0] cos;
  logic signed [PHASE_W-1:0] sin;
  logic                      sincos_tvalid;

  modport master (output phase, phase_tvalid, input cos, sin, sincos_tvalid);
  modport slave  (input phase, phase_tvalid, output cos, sin, sincos_tvalid);

endinterface

// File: rtl/sincos_phase_sched_phase_wrap.sv
// Combinational 17-bit phase add with one wrap correction into [-pi, pi).
module sincos_phase_sched_phase_wrap
  import sincos_phase_sched_pkg::*;
(
  input  logic signed [PHASE_W-1:0] a,
  input  logic signed [PHASE_W-1:0] b,
  output logic signed [PHASE_W-1:0] y
);

  logic signed [PHASE_W:0] sum;
  logic signed [PHASE_W:0] fix;
  logic                    unused_fix_msb;

  always_comb begin
    sum = {a[PHASE_W-1], a} + {b[PHASE_W-1], b};
    if (sum >= PI_POS) begin
      fix = sum - TWO_PI;
    end else if (sum < PI_NEG) begin
      fix = sum + TWO_PI;
    end else begin
      fix = sum;
    end
  end

  // Both operands are inside [-pi, pi), so the corrected value always fits PHASE_W bits.
  assign y              = fix[PHASE_W-1:0];
  assign unused_fix_msb = fix[PHASE_W];

endmodule

// File: rtl/sincos_phase_sched.sv
// Per tick, issues legs A, A-2pi/3, A+2pi/3 to the shared core and strobes the aligned sin set
// (out_valid 5 cycles after tick with a 2-cycle core; one more with SINCOS_AMP_SCALE_EN).
module sincos_phase_sched
  import sincos_phase_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      tick,
  input  logic signed [PHASE_W-1:0] freq_word,
  input  logic                      clr_flags,
`ifdef SINCOS_AMP_SCALE_EN
  input  logic        [15:0]        amp,
`endif
  sincos_phase_sched_if.master      core,
  output logic signed [PHASE_W-1:0] sin_a,
  output logic signed [PHASE_W-1:0] sin_b,
  output logic signed [PHASE_W-1:0] sin_c,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef SINCOS_AMP_SCALE_EN
  localparam bit AMP_EN = 1'b1;
`else
  localparam bit AMP_EN = 1'b0;
`endif

  state_t                    state;
  logic signed [PHASE_W-1:0] theta;
  logic signed [PHASE_W-1:0] theta_nxt;
  logic signed [PHASE_W-1:0] phase_b;
  logic signed [PHASE_W-1:0] phase_c;
  logic [1:0]                cnt;
  logic [TW-1:0]             tcnt;
  logic                      go;
  logic                      collecting;
  logic                      acc;
  logic                      last;
  logic                      unused_cos;

  sincos_phase_sched_phase_wrap u_wrap_theta (.a(theta), .b(freq_word),    .y(theta_nxt));
  sincos_phase_sched_phase_wrap u_wrap_b     (.a(theta), .b(NEG_TWO_PI_3), .y(phase_b));
  sincos_phase_sched_phase_wrap u_wrap_c     (.a(theta), .b(TWO_PI_3),     .y(phase_c));

  assign go         = tick & en;
  assign collecting = (state == ST_ISS_A) || (state == ST_ISS_B) ||
                      (state == ST_ISS_C) || (state == ST_WAIT);
  assign acc        = core.sincos_tvalid && collecting && (cnt != 2'd3);
  assign last       = acc && (cnt == 2'd2);
  assign busy       = (state != ST_IDLE);
  assign unused_cos = ^core.cos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      theta             <= '0;
      core.phase        <= '0;
      core.phase_tvalid <= 1'b0;
      cnt               <= '0;
      tcnt              <= '0;
      out_valid         <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Flags are cleared first so a same-cycle set event below takes priority.
      if (clr_flags) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (go && busy) begin
        overrun <= 1'b1;
      end
      if (acc) begin
        cnt <= cnt + 2'd1;
      end
      case (state)
        ST_IDLE: begin
          if (go) begin
            theta             <= theta_nxt;
            core.phase        <= theta_nxt;
            core.phase_tvalid <= 1'b1;
            cnt               <= '0;
            state             <= ST_ISS_A;
          end
        end
        ST_ISS_A: begin
          core.phase <= phase_b;
          state      <= ST_ISS_B;
        end
        ST_ISS_B: begin
          core.phase <= phase_c;
          state      <= ST_ISS_C;
        end
        ST_ISS_C: begin
          core.phase        <= '0;
          core.phase_tvalid <= 1'b0;
          tcnt              <= TW'(1);
          if (last || (cnt == 2'd3)) begin
            state     <= ST_DONE;
            out_valid <= !AMP_EN;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (last) begin
            state     <= ST_DONE;
            out_valid <= !AMP_EN;
          end else if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_DONE: begin
          state     <= AMP_EN ? ST_OUT : ST_IDLE;
          out_valid <= AMP_EN;
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic                      cap_vld;
  logic [1:0]                cap_idx;
  logic signed [PHASE_W-1:0] cap_dat;

`ifdef SINCOS_AMP_SCALE_EN
  logic              prod_vld;
  logic [1:0]        prod_idx;
  logic signed [32:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      prod_idx <= '0;
      prod     <= '0;
    end else begin
      prod_vld <= acc;
      prod_idx <= cnt;
      prod     <= 33'(core.sin) * 33'($signed({1'b0, amp}));
    end
  end

  assign cap_vld = prod_vld;
  assign cap_idx = prod_idx;
  assign cap_dat = sat16(prod >>> 15);
`else
  assign cap_vld = acc;
  assign cap_idx = cnt;
  assign cap_dat = core.sin;
`endif

  logic signed [PHASE_W-1:0] sh_a;
  logic signed [PHASE_W-1:0] sh_b;

  // A and B land in shadows; the visible set only changes when C completes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sin_a <= '0;
      sin_b <= '0;
      sin_c <= '0;
    end else if (cap_vld) begin
      case (cap_idx)
        2'd0: sh_a <= cap_dat;
        2'd1: sh_b <= cap_dat;
        default: begin
          sin_a <= sh_a;
          sin_b <= sh_b;
          sin_c <= cap_dat;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_phase_sched.sv
// Directed bench: core model echoes phase as sin after a programmable latency; scoreboard queues
// hold expected phase requests and result sets pushed at each tick.
module tb_sincos_phase_sched;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               tick;
  logic signed [15:0] freq_word;
  logic               clr_flags;
  logic signed [15:0] sin_a;
  logic signed [15:0] sin_b;
  logic signed [15:0] sin_c;
  logic               out_valid;
  logic               busy;
  logic               overrun;
  logic               timeout_err;
`ifdef SINCOS_AMP_SCALE_EN
  logic [15:0]        amp;
  localparam int OV_LAT = 6;
`else
  localparam int OV_LAT = 5;
`endif

  sincos_phase_sched_if sif ();

  sincos_phase_sched #(.TIMEOUT_CYC(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .freq_word  (freq_word),
    .clr_flags  (clr_flags),
`ifdef SINCOS_AMP_SCALE_EN
    .amp        (amp),
`endif
    .core       (sif),
    .sin_a      (sin_a),
    .sin_b      (sin_b),
    .sin_c      (sin_c),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic signed [15:0] v; } rsp_t;
  typedef struct { int a; int b; int c; } set_t;

  rsp_t rq[$];
  set_t exp_set[$];
  int   exp_ph[$];
  set_t last_set;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0;
  int last_issc = 0;
  int tick_cyc = 0;
  int ov_cyc = 0;
  int nvalid = 0;
  int lat = 2;
  int mtheta = 0;
  int v0;
  bit drop_third = 1'b0;

  function automatic int wrapm(input int x);
    if (x >= 25736) return x - 51472;
    if (x < -25736) return x + 51472;
    return x;
  endfunction

  function automatic int scale(input int x);
`ifdef SINCOS_AMP_SCALE_EN
    int y;
    y = (x * int'(amp)) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: core model drives results after the edge, monitors sample at the falling edge.
  task automatic cycle();
    rsp_t r;
    set_t s;
    int   p;
    @(posedge clk);
    #1;
    cyc++;
    sif.sincos_tvalid = 1'b0;
    sif.sin = '0;
    sif.cos = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      sif.sincos_tvalid = 1'b1;
      sif.sin = r.v;
      sif.cos = ~r.v;
    end
    @(negedge clk);
    if (sif.phase_tvalid === 1'b1) begin
      run++;
      if (run == 3) last_issc = cyc;
      if (exp_ph.size() > 0) begin
        p = exp_ph.pop_front();
        chk("phase", sif.phase, p);
      end else begin
        chk("phase_extra", sif.phase_tvalid, 0);
      end
      if (!(drop_third && run == 3)) begin
        r.due = cyc + lat;
        r.v = sif.phase;
        rq.push_back(r);
      end
    end else begin
      run = 0;
    end
    if (out_valid === 1'b1) begin
      nvalid++;
      ov_cyc = cyc;
      if (exp_set.size() > 0) begin
        s = exp_set.pop_front();
        chk("set_a", sin_a, s.a);
        chk("set_b", sin_b, s.b);
        chk("set_c", sin_c, s.c);
        last_set = s;
      end else begin
        chk("ov_extra", out_valid, 0);
      end
    end
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_tick(input bit start, input bit push_set);
    set_t s;
    tick = 1'b1;
    if (start) begin
      mtheta = wrapm(mtheta + int'(freq_word));
      exp_ph.push_back(mtheta);
      exp_ph.push_back(wrapm(mtheta - 17157));
      exp_ph.push_back(wrapm(mtheta + 17157));
      if (push_set) begin
        s.a = scale(mtheta);
        s.b = scale(wrapm(mtheta - 17157));
        s.c = scale(wrapm(mtheta + 17157));
        exp_set.push_back(s);
      end
    end
    cycle();
    tick_cyc = cyc;
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    tick = 1'b0;
    clr_flags = 1'b0;
    freq_word = 16'sd256;
    sif.sin = '0;
    sif.cos = '0;
    sif.sincos_tvalid = 1'b0;
`ifdef SINCOS_AMP_SCALE_EN
    amp = 16'h4000;
`endif
    run_n(3);
    chk("rst_phase", sif.phase, 0);
    chk("rst_tvalid", sif.phase_tvalid, 0);
    chk("rst_sin_a", sin_a, 0);
    chk("rst_sin_b", sin_b, 0);
    chk("rst_sin_c", sin_c, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    cycle();

    // Basic set from theta=0
    v0 = nvalid;
    do_tick(1'b1, 1'b1);
    chk("t1_issa_vld", sif.phase_tvalid, 1);
    chk("t1_issa_ph", sif.phase, 256);
    chk("t1_busy", busy, 1);
    run_n(8);
    chk("t1_ov_count", nvalid - v0, 1);
    chk("t1_ov_lat", ov_cyc - tick_cyc, OV_LAT);
    chk("t1_sin_a", sin_a, scale(256));
    chk("t1_sin_b", sin_b, scale(-16901));
    chk("t1_sin_c", sin_c, scale(17413));
    chk("t1_idle", busy, 0);

    // Walk theta to 25600, then cross +pi
    repeat (99) begin
      do_tick(1'b1, 1'b1);
      run_n(7);
    end
    do_tick(1'b1, 1'b1);
    chk("t2_issa_wrap", sif.phase, -25616);
    run_n(7);
    chk("t2_sin_a", sin_a, scale(-25616));
    chk("t2_sin_b", sin_b, scale(8699));
    chk("t2_sin_c", sin_c, scale(-8459));

    // Timeout: core drops the third result
    drop_third = 1'b1;
    v0 = nvalid;
    do_tick(1'b1, 1'b0);
    run_n(2);
    chk("t3_issc_cyc", last_issc, tick_cyc + 2);
    while (cyc < last_issc + 31) cycle();
    chk("t3_to_early", timeout_err, 0);
    chk("t3_busy_early", busy, 1);
    cycle();
    chk("t3_to_set", timeout_err, 1);
    chk("t3_idle", busy, 0);
    chk("t3_no_ov", nvalid - v0, 0);
    chk("t3_keep_a", sin_a, last_set.a);
    chk("t3_keep_b", sin_b, last_set.b);
    chk("t3_keep_c", sin_c, last_set.c);
    drop_third = 1'b0;
    v0 = nvalid;
    do_tick(1'b1, 1'b1);
    run_n(7);
    chk("t3_recover", nvalid - v0, 1);
    chk("t3_sticky", timeout_err, 1);
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    chk("t3_clr", timeout_err, 0);

    // Overrun: tick during WAIT is dropped
    do_tick(1'b1, 1'b1);
    run_n(3);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    chk("t4_overrun", overrun, 1);
    run_n(6);
    do_tick(1'b1, 1'b1);
    run_n(7);
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    chk("t4_clr", overrun, 0);
    do_tick(1'b1, 1'b1);
    run_n(2);
    clr_flags = 1'b1;
    tick = 1'b1;
    cycle();
    clr_flags = 1'b0;
    tick = 1'b0;
    chk("t4_set_wins", overrun, 1);
    run_n(7);
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    en = 1'b0;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    en = 1'b1;
    chk("t4_en_busy", busy, 0);
    chk("t4_en_overrun", overrun, 0);
    run_n(3);

    // Reset in WAIT with results still in flight
    lat = 6;
    v0 = nvalid;
    do_tick(1'b1, 1'b0);
    run_n(3);
    chk("t5_busy", busy, 1);
    rst_n = 1'b0;
    mtheta = 0;
    cycle();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tvalid", sif.phase_tvalid, 0);
    chk("t5_rst_sin_a", sin_a, 0);
    rst_n = 1'b1;
    run_n(8);
    chk("t5_late_a", sin_a, 0);
    chk("t5_late_b", sin_b, 0);
    chk("t5_late_c", sin_c, 0);
    chk("t5_late_busy", busy, 0);
    chk("t5_late_ov", nvalid - v0, 0);
    chk("t5_late_flags", overrun | timeout_err, 0);
    lat = 2;
    do_tick(1'b1, 1'b1);
    chk("t5_restart_ph", sif.phase, 256);
    run_n(7);
    chk("t5_restart_ov", nvalid - v0, 1);

    chk("left_phase", exp_ph.size(), 0);
    chk("left_sets", exp_set.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
